// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage with PC register and IF/ID pipeline register.
// Optional stall-cycle counter enabled by defining IF_STALL_COUNT_EN.
module if_stage_pipe #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
  parameter logic [31:0]           BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hazard,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_data,
  input  logic                  imem_ready,
  output logic [ADDR_WIDTH-1:0] PC_out,
  output logic [31:0]           instruction_out,
  output logic                  valid_out,
  output logic [31:0]           stall_count
);

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [31:0]           instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic                  stall_cycle;
  logic [ADDR_WIDTH-1:0] pc_plus4;

  // Modulo-2^ADDR_WIDTH increment; wraps silently at the top of the space.
  assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

  // Priority: branch redirect > hazard freeze > memory wait > normal fetch.
  always_comb begin
    pc_d        = pc_q;
    pc_out_d    = pc_out_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    stall_cycle = 1'b0;
    if (branch_taken) begin
      pc_d     = {branch_addr[ADDR_WIDTH-1:2], 2'b00};
      pc_out_d = '0;
      instr_d  = BUBBLE_INSTR;
      valid_d  = 1'b0;
    end else if (hazard) begin
      stall_cycle = 1'b1;
    end else if (!imem_ready) begin
      pc_out_d    = '0;
      instr_d     = BUBBLE_INSTR;
      valid_d     = 1'b0;
      stall_cycle = 1'b1;
    end else begin
      pc_d     = {pc_plus4[ADDR_WIDTH-1:2], 2'b00};
      pc_out_d = pc_plus4;
      instr_d  = imem_data;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC_ALIGNED;
      pc_out_q <= '0;
      instr_q  <= BUBBLE_INSTR;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

`ifdef IF_STALL_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of freeze and wait-state cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cycle && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  logic unused_stall;
  assign unused_stall = stall_cycle;
  assign stall_count  = 32'h0;
`endif

  assign imem_addr       = pc_q;
  assign PC_out          = pc_out_q;
  assign instruction_out = instr_q;
  assign valid_out       = valid_q;

endmodule

// File: tb/tb_if_stage_pipe.sv
// Directed bench for if_stage_pipe: fetch, hazard, wait state, branch, wrap, async reset.
module tb_if_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic [31:0] PC_out;
  logic [31:0] instruction_out;
  logic        valid_out;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

`ifdef IF_STALL_COUNT_EN
  localparam bit SC_EN = 1'b1;
`else
  localparam bit SC_EN = 1'b0;
`endif

  if_stage_pipe #(
    .ADDR_WIDTH  (32),
    .RESET_PC    (32'h0000_0000),
    .BUBBLE_INSTR(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hazard         (hazard),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .imem_ready     (imem_ready),
    .PC_out         (PC_out),
    .instruction_out(instruction_out),
    .valid_out      (valid_out),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_sc(input string tag, input int n);
    check(tag, stall_count, SC_EN ? 32'(n) : 32'h0);
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc_o,
                           input logic [31:0] ins, input logic v, input logic [31:0] addr);
    check({tag, ".pc_out"}, PC_out, pc_o);
    check({tag, ".instr"}, instruction_out, ins);
    check({tag, ".valid"}, {31'b0, valid_out}, {31'b0, v});
    check({tag, ".imem_addr"}, imem_addr, addr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; hazard = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    imem_data = '0; imem_ready = 1'b0;
    #1;
    check_out("reset", 32'h0, 32'h0, 1'b0, 32'h0);
    check_sc("reset.sc", 0);
    step(); step();
    rst = 1'b0;

    // Three fetches with a two-cycle hazard freeze after the second.
    imem_ready = 1'b1; imem_data = 32'hE3A0_1001;
    check("fetch0.imem_addr", imem_addr, 32'h0);
    step();
    check_out("fetch1", 32'h4, 32'hE3A0_1001, 1'b1, 32'h4);
    imem_data = 32'hE3A0_2002;
    step();
    check_out("fetch2", 32'h8, 32'hE3A0_2002, 1'b1, 32'h8);

    hazard = 1'b1; imem_data = 32'hE3A0_3003;
    step();
    check_out("hazard1", 32'h8, 32'hE3A0_2002, 1'b1, 32'h8);
    step();
    check_out("hazard2", 32'h8, 32'hE3A0_2002, 1'b1, 32'h8);
    check_sc("hazard2.sc", 2);

    hazard = 1'b0;
    step();
    check_out("fetch3", 32'hC, 32'hE3A0_3003, 1'b1, 32'hC);

    // One wait state inserts a bubble and holds the PC.
    imem_ready = 1'b0;
    step();
    check_out("wait", 32'h0, 32'h0, 1'b0, 32'hC);
    check_sc("wait.sc", 3);
    imem_ready = 1'b1; imem_data = 32'hE3A0_4004;
    step();
    check_out("after_wait", 32'h10, 32'hE3A0_4004, 1'b1, 32'h10);

    // Branch beats hazard and wait state; target is word-aligned.
    branch_taken = 1'b1; branch_addr = 32'h0000_0103; hazard = 1'b1; imem_ready = 1'b0;
    step();
    check_out("branch", 32'h0, 32'h0, 1'b0, 32'h100);
    check_sc("branch.sc", 3);
    branch_taken = 1'b0; hazard = 1'b0; imem_ready = 1'b1; imem_data = 32'hE3A0_5005;
    step();
    check_out("post_branch", 32'h104, 32'hE3A0_5005, 1'b1, 32'h104);

    // Back-to-back branches: last target wins, then wrap past the top.
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFF0;
    step();
    check_out("br_a", 32'h0, 32'h0, 1'b0, 32'hFFFF_FFF0);
    branch_addr = 32'hFFFF_FFFC;
    step();
    check_out("br_b", 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC);
    branch_taken = 1'b0; imem_data = 32'hE3A0_6006;
    step();
    check_out("wrap", 32'h0, 32'hE3A0_6006, 1'b1, 32'h0);

    // Asynchronous reset between edges during a stall.
    hazard = 1'b1;
    step();
    check_sc("pre_rst.sc", 4);
    #2;
    rst = 1'b1;
    #1;
    check_out("async_rst", 32'h0, 32'h0, 1'b0, 32'h0);
    check_sc("async_rst.sc", 0);
    #3;
    rst = 1'b0; hazard = 1'b0; imem_ready = 1'b1; imem_data = 32'hE3A0_7007;
    step();
    check_out("restart", 32'h4, 32'hE3A0_7007, 1'b1, 32'h4);
    check_sc("restart.sc", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage_pipe.md
Name: if_stage_pipe

Overview:
Instruction-fetch stage plus IF/ID pipeline register, sitting directly upstream of the decode stage. Holds the program counter (PC) and drives the instruction-memory address. Produces the {PC+4, instruction, valid} bundle that decode consumes. Handles the decode-hazard freeze, instruction-memory wait states, and branch redirect/flush from the execute stage.

Parameters:
ADDR_WIDTH, 32, PC and branch-address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
BUBBLE_INSTR, 32'h0000_0000, instruction word driven when the IF/ID slot is empty

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
hazard  input  1  freeze request from the hazard unit; holds PC and IF/ID
branch_taken  input  1  execute-stage branch resolved taken; redirect and flush
branch_addr  input  ADDR_WIDTH  branch target from execute
imem_addr  output  ADDR_WIDTH  instruction-memory address; equals current PC, combinational
imem_data  input  32  instruction word returned for imem_addr
imem_ready  input  1  imem_data valid this cycle; 0 means wait state
PC_out  output  ADDR_WIDTH  registered PC+4 of the fetched instruction, to decode
instruction_out  output  32  registered instruction to decode
valid_out  output  1  registered; 1 means instruction_out is a real instruction
stall_count  output  32  stall-cycle counter; see Optional Feature

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - PC = RESET_PC, PC_out = 0, instruction_out = BUBBLE_INSTR, valid_out = 0, stall_count = 0.
  - Reset asserted mid-stall or mid-branch discards all pending state.
- imem_addr = PC, combinational from the PC register. The PC is always word-aligned: bits [1:0] are forced to 00 on every load.
- Per-cycle update priority, evaluated at the rising edge with rst low:
  1. branch_taken=1 (wins over hazard and imem_ready):
     - PC <= {branch_addr[ADDR_WIDTH-1:2], 2'b00}.
     - IF/ID <= bubble: valid_out=0, instruction_out=BUBBLE_INSTR, PC_out=0.
  2. else hazard=1:
     - PC holds.
     - IF/ID holds all three fields unchanged.
  3. else imem_ready=0:
     - PC holds.
     - IF/ID <= bubble, because decode has consumed the previous slot.
  4. else (normal fetch):
     - PC <= PC+4.
     - IF/ID <= {PC+4, imem_data, 1}.
- Arithmetic: PC+4 is modulo 2^ADDR_WIDTH; 0xFFFF_FFFC wraps to 0x0000_0000 with no flag.
- Latency: an instruction presented at imem_data with imem_ready=1 appears on instruction_out one cycle later.
- Back-to-back branch_taken: each cycle redirects again; the last target wins and valid_out stays 0.
- hazard together with imem_ready=0: the hazard rule applies (hold, no bubble).
- No combinational path from any input to PC_out, instruction_out or valid_out.

Optional Feature:
- Macro: IF_STALL_COUNT_EN.
- Defined:
  - stall_count increments by 1 on every edge where rule 2 or rule 3 applies.
  - It saturates at 32'hFFFF_FFFF.
  - It is cleared only by rst.
- Undefined:
  - stall_count is tied to 32'h0.
  - No counter flops are synthesized.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then 3 cycles with imem_ready=1 returning 0xE3A0_1001, 0xE3A0_2002, 0xE3A0_3003:
  - imem_addr steps 0, 4, 8.
  - Outputs one cycle later are PC_out=4/8/0xC, valid_out=1, matching instructions.
- hazard=1 for 2 cycles at PC=8:
  - imem_addr stays 8.
  - PC_out=8 and instruction_out=0xE3A0_2002 are held.
  - stall_count=2 when IF_STALL_COUNT_EN is defined, 0 when it is not.
- imem_ready=0 for 1 cycle at PC=0xC:
  - valid_out=0 and instruction_out=BUBBLE_INSTR next cycle.
  - PC still 0xC.
  - Next ready cycle loads PC_out=0x10.
- branch_taken=1, branch_addr=0x0000_0103, with hazard=1 and imem_ready=0 in the same cycle:
  - Next cycle imem_addr=0x100 and valid_out=0.
  - The following fetch gives PC_out=0x104.
- Branch to 0xFFFF_FFFC, then one ready fetch:
  - PC_out=0x0000_0000 and imem_addr=0.
- Assert rst asynchronously between edges during a stall:
  - Outputs go to reset values immediately.
  - After release, fetch restarts at RESET_PC.
